seg7_scan_driver: RTL

Time-multiplexed driver for the 4-digit common-anode 7-segment display (D1 bank). It takes a 16-bit hex value, commits it to a shadow register only at frame boundaries so a frame never shows a mix of old and new digits, and cycles the four anodes. The per-digit hex-to-segment encoding is the same one used by the single-digit encoder, and this block feeds the D1 pins directly.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_hex_lut.sv | 11 +
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display drivers: hex glyph table,
// idle output constants and the scan FSM state type.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic {GAP, DRIVE} state_e;

  // Active-low glyphs, bits 6:0 = g..a.
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational nibble to active-low segment pattern lookup.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg7(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with frame-synchronous value commit,
// inter-digit blanking, per-digit dp/blank and leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned TICK_COUNT   = 100000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  blank,
  input  logic        lz_en,
  output logic [7:0]  D1_seg,
  output logic [3:0]  D1_a,
  output logic        frame_start
);

  localparam int unsigned CntMax = (TICK_COUNT > BLANK_CYCLES) ? TICK_COUNT : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              started_q, started_d;
  logic [15:0]       shadow_q, pending_q;
  logic              pend_v_q;
  logic              tick_done, gap_done, boundary;
  logic [3:0]        nibble;
  logic [6:0]        glyph;
  logic              dark, upper_zero;
  logic [7:0]        seg_d;
  logic [3:0]        an_d;
  logic              fs_d;

  assign tick_done = (cnt_q == CntW'(TICK_COUNT - 1));
  assign gap_done  = (BLANK_CYCLES == 0) || (cnt_q == CntW'(BLANK_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    started_d = started_q;
    unique case (state_q)
      DRIVE: begin
        if (tick_done) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) idx_d = idx_q + 2'd1;
          else                   state_d = GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          cnt_d     = '0;
          state_d   = DRIVE;
          started_d = 1'b1;
          // The first DRIVE after reset is digit 0, so skip the advance once.
          if (started_q) idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = GAP;
    endcase
  end

  assign boundary = (state_d == DRIVE) && (idx_d == 2'd0) &&
                    !((state_q == DRIVE) && (idx_q == 2'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GAP;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      started_q <= 1'b0;
      shadow_q  <= 16'h0000;
      pending_q <= 16'h0000;
      pend_v_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      if (load) pending_q <= value;
      if (boundary) begin
        pend_v_q <= 1'b0;
        if (load)          shadow_q <= value;
        else if (pend_v_q) shadow_q <= pending_q;
      end else if (load) begin
        pend_v_q <= 1'b1;
      end
    end
  end

  assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

  seg7_hex_lut u_lut (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    upper_zero = 1'b0;
    unique case (idx_q)
      2'd0: upper_zero = 1'b0;
      2'd1: upper_zero = (shadow_q[15:4] == 12'h000);
      2'd2: upper_zero = (shadow_q[15:8] == 8'h00);
      2'd3: upper_zero = (shadow_q[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign dark = blank[idx_q] || (lz_en && upper_zero);

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = ANODE_OFF;
    fs_d  = 1'b0;
    if (state_q == DRIVE) begin
      seg_d = {~dp_en[idx_q], dark ? 7'h7F : glyph};
      an_d  = ~(4'b0001 << idx_q);
      fs_d  = (idx_q == 2'd0) && (cnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      D1_seg      <= SEG_OFF;
      D1_a        <= ANODE_OFF;
      frame_start <= 1'b0;
    end else begin
      D1_seg      <= seg_d;
      D1_a        <= an_d;
      frame_start <= fs_d;
    end
  end

endmodule
